// File: rtl/audio_rx_deser.sv
// audio_rx_deser: I2S / left-justified serial audio receiver.
// Aligns to the LR clock, deserialises one left and one right word per frame,
// and writes {left, right} to a downstream FIFO. A frame whose commit meets a
// full FIFO is dropped and flagged on overflow_sig.
// Optional feature: define AUDIO_RX_OVF_CNT_EN to build the saturating
// dropped-frame counter behind ovf_count; otherwise ovf_count is tied to zero.
module audio_rx_deser #(
    parameter int DATA_WIDTH    = 16,
    parameter int I2S_MODE      = 1,
    parameter int OVF_CNT_WIDTH = 16
) (
    input  logic                      AUD_BCLK,
    input  logic                      reset_n,
    input  logic                      AUD_ADC_CLK,
    input  logic                      AUD_ADC_DATA,
    input  logic                      wrfull_sig,
    output logic                      wrreq_sig,
    output logic [2*DATA_WIDTH-1:0]   data_sig,
    output logic                      locked,
    output logic                      overflow_sig,
    output logic [OVF_CNT_WIDTH-1:0]  ovf_count
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DATA_WIDTH);
    localparam logic [IW-1:0] MSB_IDX  = IW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

    state_t                  state_reg, state_next;
    logic                    lrc_q;
    logic                    lrc_rise, lrc_fall;
    logic [CW-1:0]           cnt_reg, cnt_next;
    logic [DATA_WIDTH-1:0]   shift_reg, shift_next;
    logic [DATA_WIDTH-1:0]   left_reg, left_next;
    logic [DATA_WIDTH-1:0]   slot_word;
    logic [IW-1:0]           bit_idx;
    logic                    slot_start;
    logic                    commit, commit_ok, commit_drop;

    assign lrc_rise    = ~lrc_q & AUD_ADC_CLK;
    assign lrc_fall    = lrc_q & ~AUD_ADC_CLK;
    assign bit_idx     = MSB_IDX - cnt_reg[IW-1:0];
    assign locked      = (state_reg != SYNC);
    assign commit_ok   = commit & ~wrfull_sig;
    assign commit_drop = commit & wrfull_sig;

    // Next state, slot start/finish and MSB-first bit placement.
    // Bits are written by index so a short slot stays left-aligned with zero LSBs.
    // In I2S mode the bit sampled on an LRC edge still belongs to the slot that
    // is ending (the one-BCLK delay), so it is merged into the finished word.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        shift_next = shift_reg;
        left_next  = left_reg;
        slot_word  = shift_reg;
        slot_start = 1'b0;
        commit     = 1'b0;
        if (I2S_MODE != 0 && cnt_reg < FULL_CNT) begin
            slot_word[bit_idx] = AUD_ADC_DATA;
        end
        case (state_reg)
            SYNC: begin
                if (lrc_rise) begin
                    state_next = LEFT;
                    slot_start = 1'b1;
                end
            end
            LEFT: begin
                if (lrc_fall) begin
                    state_next = RIGHT;
                    slot_start = 1'b1;
                    left_next  = slot_word;
                end
            end
            RIGHT: begin
                if (lrc_rise) begin
                    state_next = LEFT;
                    slot_start = 1'b1;
                    commit     = 1'b1;
                end
            end
            default: state_next = SYNC;
        endcase
        if (slot_start) begin
            shift_next = '0;
            cnt_next   = '0;
            if (I2S_MODE == 0) begin
                shift_next[MSB_IDX] = AUD_ADC_DATA;
                cnt_next            = CW'(1);
            end
        end else if (state_reg != SYNC && cnt_reg < FULL_CNT) begin
            shift_next[bit_idx] = AUD_ADC_DATA;
            cnt_next            = cnt_reg + 1'b1;
        end
    end

    // Alignment state, LRC history and per-slot capture registers.
    always_ff @(posedge AUD_BCLK or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= SYNC;
            lrc_q     <= 1'b1;
            cnt_reg   <= '0;
            shift_reg <= '0;
            left_reg  <= '0;
        end else begin
            state_reg <= state_next;
            lrc_q     <= AUD_ADC_CLK;
            cnt_reg   <= cnt_next;
            shift_reg <= shift_next;
            left_reg  <= left_next;
        end
    end

    // Frame commit: write strobe, held output word and drop pulse.
    always_ff @(posedge AUD_BCLK or negedge reset_n) begin
        if (!reset_n) begin
            wrreq_sig    <= 1'b0;
            overflow_sig <= 1'b0;
            data_sig     <= '0;
        end else begin
            wrreq_sig    <= commit_ok;
            overflow_sig <= commit_drop;
            if (commit_ok) begin
                data_sig <= {left_reg, slot_word};
            end
        end
    end

`ifdef AUDIO_RX_OVF_CNT_EN
    logic [OVF_CNT_WIDTH-1:0] ovf_cnt_reg;

    // Dropped-frame counter, sticks at all-ones.
    always_ff @(posedge AUD_BCLK or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_reg <= '0;
        end else if (commit_drop && ovf_cnt_reg != '1) begin
            ovf_cnt_reg <= ovf_cnt_reg + 1'b1;
        end
    end

    assign ovf_count = ovf_cnt_reg;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_audio_rx_deser.sv
// Testbench for audio_rx_deser: slot-level stimulus tables are expanded into a
// per-cycle LRC/data stream; expected frames come from the slot words directly.
module tb_audio_rx_deser;

`ifdef AUDIO_RX_OVF_CNT_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n = 1'b0;
    logic a_lrc = 1'b1, a_dat = 1'b0, a_full = 1'b0;
    logic b_lrc = 1'b1, b_dat = 1'b0, b_full = 1'b0;

    logic        a_wr, a_ovf, a_lock;
    logic [31:0] a_data;
    logic [15:0] a_cnt;
    logic        c_wr, c_ovf, c_lock;
    logic [31:0] c_data;
    logic [1:0]  c_cnt;
    logic        b_wr, b_ovf, b_lock;
    logic [47:0] b_data;
    logic [15:0] b_cnt;

    audio_rx_deser #(.DATA_WIDTH(16), .I2S_MODE(1), .OVF_CNT_WIDTH(16)) u_a (
        .AUD_BCLK(clk), .reset_n(rst_n), .AUD_ADC_CLK(a_lrc), .AUD_ADC_DATA(a_dat),
        .wrfull_sig(a_full), .wrreq_sig(a_wr), .data_sig(a_data), .locked(a_lock),
        .overflow_sig(a_ovf), .ovf_count(a_cnt));

    audio_rx_deser #(.DATA_WIDTH(16), .I2S_MODE(1), .OVF_CNT_WIDTH(2)) u_c (
        .AUD_BCLK(clk), .reset_n(rst_n), .AUD_ADC_CLK(a_lrc), .AUD_ADC_DATA(a_dat),
        .wrfull_sig(a_full), .wrreq_sig(c_wr), .data_sig(c_data), .locked(c_lock),
        .overflow_sig(c_ovf), .ovf_count(c_cnt));

    audio_rx_deser #(.DATA_WIDTH(24), .I2S_MODE(0), .OVF_CNT_WIDTH(16)) u_b (
        .AUD_BCLK(clk), .reset_n(rst_n), .AUD_ADC_CLK(b_lrc), .AUD_ADC_DATA(b_dat),
        .wrfull_sig(b_full), .wrreq_sig(b_wr), .data_sig(b_data), .locked(b_lock),
        .overflow_sig(b_ovf), .ovf_count(b_cnt));

    int n_tests = 0;
    int n_fail  = 0;
    int cur_t   = -1;
    int n_wr, n_ovf;

    // slot table: LRC level, length in BCLKs, word (MSB sent first), FIFO full during slot
    int          slot_lvl[$];
    int          slot_len[$];
    logic [31:0] slot_word[$];
    bit          slot_full[$];

    // expanded per-cycle stream and expectations
    bit          lrc_arr[];
    bit          dat_arr[];
    bit          full_arr[];
    int          cmt_at[];
    logic [63:0] frame_at[];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, cur_t, obs, exp);
        end
    endtask

    function automatic logic [63:0] sat_cnt(input int drops, input int width);
        logic [63:0] lim;
        lim = (64'd1 << width) - 64'd1;
        if (!OVF_EN) return 64'd0;
        return (64'(drops) > lim) ? lim : 64'(drops);
    endfunction

    task automatic clear_slots();
        slot_lvl.delete();
        slot_len.delete();
        slot_word.delete();
        slot_full.delete();
    endtask

    task automatic add_slot(input int lvl, input int len, input logic [31:0] word, input bit full);
        slot_lvl.push_back(lvl);
        slot_len.push_back(len);
        slot_word.push_back(word);
        slot_full.push_back(full);
    endtask

    // random left/right pairs; the full flag sits on the left slot whose edge commits
    task automatic add_rand_frames(input int cnt, input int dw, input int minl, input int maxl);
        logic [31:0] mask;
        mask = (32'h1 << dw) - 32'h1;
        for (int k = 0; k < cnt; k++) begin
            add_slot(1, $urandom_range(maxl, minl), $urandom & mask, ($urandom_range(0, 3) == 0));
            add_slot(0, $urandom_range(maxl, minl), $urandom & mask, 1'b0);
        end
    endtask

    task automatic reset_all(input int grp, input int lvl);
        @(negedge clk);
        a_lrc = (grp == 0) ? 1'(lvl) : 1'b1;
        b_lrc = (grp == 1) ? 1'(lvl) : 1'b1;
        a_dat = 1'b0; b_dat = 1'b0; a_full = 1'b0; b_full = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        cur_t = -1;
        chk("rst_a_wrreq",  64'(a_wr),   64'd0);
        chk("rst_a_ovf",    64'(a_ovf),  64'd0);
        chk("rst_a_locked", 64'(a_lock), 64'd0);
        chk("rst_a_data",   64'(a_data), 64'd0);
        chk("rst_a_cnt",    64'(a_cnt),  64'd0);
        chk("rst_c_wrreq",  64'(c_wr),   64'd0);
        chk("rst_c_ovf",    64'(c_ovf),  64'd0);
        chk("rst_c_locked", 64'(c_lock), 64'd0);
        chk("rst_c_data",   64'(c_data), 64'd0);
        chk("rst_c_cnt",    64'(c_cnt),  64'd0);
        chk("rst_b_wrreq",  64'(b_wr),   64'd0);
        chk("rst_b_ovf",    64'(b_ovf),  64'd0);
        chk("rst_b_locked", 64'(b_lock), 64'd0);
        chk("rst_b_data",   64'(b_data), 64'd0);
        chk("rst_b_cnt",    64'(b_cnt),  64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // grp 0: I2S 16-bit pair (u_a, u_c); grp 1: left-justified 24-bit (u_b)
    task automatic run(input int grp);
        int          dw, i2s, n, tot, T, s0, prev, drops;
        int          st[$];
        logic [31:0] cap[$];
        logic [31:0] w, c;
        logic [63:0] exp_data;
        bit          exp_wr, exp_ovf, exp_lock, b;
        dw  = (grp == 0) ? 16 : 24;
        i2s = (grp == 0) ? 1 : 0;
        n   = slot_lvl.size();
        tot = 0;
        for (int i = 0; i < n; i++) begin
            st.push_back(tot);
            tot += slot_len[i];
        end
        T = tot + 2;
        lrc_arr = new[T]; dat_arr = new[T]; full_arr = new[T];
        cmt_at = new[T]; frame_at = new[T];
        for (int t = 0; t < T; t++) begin
            dat_arr[t]  = 1'($urandom);
            lrc_arr[t]  = 1'(slot_lvl[n-1]);
            full_arr[t] = slot_full[n-1];
            cmt_at[t]   = 0;
            frame_at[t] = '0;
        end
        // sender: slot bit p goes out p cycles after the edge (+1 in I2S);
        // receiver keeps only the first dw bits, left-aligned, zero-filled
        for (int i = 0; i < n; i++) begin
            w = slot_word[i];
            c = '0;
            for (int p = 0; p < slot_len[i]; p++) begin
                lrc_arr[st[i]+p]  = 1'(slot_lvl[i]);
                full_arr[st[i]+p] = slot_full[i];
                if (p < dw) begin
                    b = 1'(w >> (dw - 1 - p));
                    dat_arr[st[i]+p+i2s] = b;
                    c = c | (32'(b) << (dw - 1 - p));
                end
            end
            cap.push_back(c);
        end
        // lock on the first rising LRC edge after reset (LRC history starts high);
        // every later rising edge closes a left/right pair
        s0 = -1;
        prev = 1;
        for (int i = 0; i < n; i++) begin
            if (s0 < 0 && slot_lvl[i] == 1 && prev == 0) s0 = i;
            prev = slot_lvl[i];
        end
        if (s0 >= 0) begin
            for (int j = s0; j + 2 < n; j += 2) begin
                cmt_at[st[j+2]]   = slot_full[j+2] ? 2 : 1;
                frame_at[st[j+2]] = (64'(cap[j]) << dw) | 64'(cap[j+1]);
            end
        end

        reset_all(grp, slot_lvl[0]);
        exp_data = '0;
        drops = 0;
        n_wr = 0;
        n_ovf = 0;
        for (int t = 0; t < T; t++) begin
            @(negedge clk);
            if (grp == 0) begin
                a_lrc = lrc_arr[t]; a_dat = dat_arr[t]; a_full = full_arr[t];
            end else begin
                b_lrc = lrc_arr[t]; b_dat = dat_arr[t]; b_full = full_arr[t];
            end
            @(posedge clk);
            #1;
            cur_t = t;
            exp_wr   = (cmt_at[t] == 1);
            exp_ovf  = (cmt_at[t] == 2);
            exp_lock = (s0 >= 0) && (t >= st[s0]);
            if (exp_wr) exp_data = frame_at[t];
            if (exp_ovf) drops++;
            if (grp == 0) begin
                if (a_wr === 1'b1) n_wr++;
                if (a_ovf === 1'b1) n_ovf++;
                chk("a_wrreq",  64'(a_wr),   64'(exp_wr));
                chk("a_ovf",    64'(a_ovf),  64'(exp_ovf));
                chk("a_locked", 64'(a_lock), 64'(exp_lock));
                chk("a_data",   64'(a_data), exp_data);
                chk("a_cnt",    64'(a_cnt),  sat_cnt(drops, 16));
                chk("c_wrreq",  64'(c_wr),   64'(exp_wr));
                chk("c_ovf",    64'(c_ovf),  64'(exp_ovf));
                chk("c_locked", 64'(c_lock), 64'(exp_lock));
                chk("c_data",   64'(c_data), exp_data);
                chk("c_cnt",    64'(c_cnt),  sat_cnt(drops, 2));
            end else begin
                if (b_wr === 1'b1) n_wr++;
                if (b_ovf === 1'b1) n_ovf++;
                chk("b_wrreq",  64'(b_wr),   64'(exp_wr));
                chk("b_ovf",    64'(b_ovf),  64'(exp_ovf));
                chk("b_locked", 64'(b_lock), 64'(exp_lock));
                chk("b_data",   64'(b_data), exp_data);
                chk("b_cnt",    64'(b_cnt),  sat_cnt(drops, 16));
            end
        end
        $display("[TB] scenario grp=%0d cycles=%0d wrreq=%0d overflow=%0d", grp, T, n_wr, n_ovf);
    endtask

    initial begin
        // I2S 16-bit, 32 BCLK slots, single frame
        clear_slots();
        add_slot(0, 5, 32'h0, 1'b0);
        add_slot(1, 32, 32'hA5C3, 1'b0);
        add_slot(0, 32, 32'h1234, 1'b0);
        add_slot(1, 5, 32'h0, 1'b0);
        run(0);
        chk("i2s32_data",   64'(a_data), 64'hA5C31234);
        chk("i2s32_wrreqs", 64'(n_wr),   64'd1);

        // short 12-BCLK slots, left-aligned and zero-filled
        clear_slots();
        add_slot(0, 6, 32'h0, 1'b0);
        add_slot(1, 12, 32'hABC0, 1'b0);
        add_slot(0, 12, 32'h1230, 1'b0);
        add_slot(1, 3, 32'h0, 1'b0);
        run(0);
        chk("short_data", 64'(a_data), 64'hABC01230);

        // random words, random slot lengths, random FIFO full
        clear_slots();
        add_slot(0, 7, 32'h0, 1'b0);
        add_rand_frames(12, 16, 3, 40);
        add_slot(1, 3, 32'h0, 1'b0);
        run(0);

        // one good commit then five dropped frames
        clear_slots();
        add_slot(0, 5, 32'h0, 1'b0);
        add_slot(1, 20, 32'h1111, 1'b0);
        add_slot(0, 20, 32'h2222, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            add_slot(1, 20, 32'($urandom_range(65535, 0)), (k != 1));
            add_slot(0, 20, 32'($urandom_range(65535, 0)), 1'b0);
        end
        add_slot(1, 4, 32'h0, 1'b1);
        run(0);
        chk("ovf_data",     64'(a_data), 64'h11112222);
        chk("ovf_wrreqs",   64'(n_wr),   64'd1);
        chk("ovf_pulses",   64'(n_ovf),  64'd5);
        chk("ovf_cnt16",    64'(a_cnt),  OVF_EN ? 64'd5 : 64'd0);
        chk("ovf_cnt2_sat", 64'(c_cnt),  OVF_EN ? 64'd3 : 64'd0);

        // reset asserted with data held, released in the middle of a left slot
        clear_slots();
        add_slot(1, 10, 32'hFFFF, 1'b0);
        add_slot(0, 32, 32'hFFFF, 1'b0);
        add_slot(1, 32, 32'h5A5A, 1'b0);
        add_slot(0, 32, 32'h0F0F, 1'b0);
        add_slot(1, 4, 32'h0, 1'b0);
        run(0);
        chk("midrst_wrreqs", 64'(n_wr),   64'd1);
        chk("midrst_data",   64'(a_data), 64'h5A5A0F0F);

        // left-justified 24-bit
        clear_slots();
        add_slot(0, 4, 32'h0, 1'b0);
        add_slot(1, 32, 32'h800001, 1'b0);
        add_slot(0, 32, 32'h7FFFFE, 1'b0);
        add_slot(1, 3, 32'h0, 1'b0);
        run(1);
        chk("lj24_data",   64'(b_data), 64'h8000017FFFFE);
        chk("lj24_wrreqs", 64'(n_wr),   64'd1);

        // left-justified 24-bit, random
        clear_slots();
        add_slot(0, 6, 32'h0, 1'b0);
        add_rand_frames(12, 24, 3, 40);
        add_slot(1, 3, 32'h0, 1'b0);
        run(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/audio_rx_deser.md
AUDIO_RX_DESER -- requirements
Module: audio_rx_deser

Interface
- REQ-001 SHALL have parameter DATA_WIDTH, default 16; bits captured per channel; legal 8..32.
- REQ-002 SHALL have parameter I2S_MODE, default 1; 1 = I2S (MSB one AUD_BCLK after LRC edge), 0 = left-justified (MSB on the LRC edge cycle).
- REQ-003 SHALL have parameter OVF_CNT_WIDTH, default 16; width of the overflow counter.
- REQ-004 SHALL have port AUD_BCLK  in  1  audio bit clock; the only clock; all logic on its rising edge.
- REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
- REQ-006 SHALL have port AUD_ADC_CLK  in  1  LR clock; 1 = left slot, 0 = right slot.
- REQ-007 SHALL have port AUD_ADC_DATA  in  1  serial ADC data, MSB first.
- REQ-008 SHALL have port wrfull_sig  in  1  downstream FIFO full.
- REQ-009 SHALL have port wrreq_sig  out  1  FIFO write strobe, one cycle per committed frame.
- REQ-010 SHALL have port data_sig  out  2*DATA_WIDTH  frame word: {left, right}, left in MSBs.
- REQ-011 SHALL have port locked  out  1  high once frame alignment is achieved.
- REQ-012 SHALL have port overflow_sig  out  1  one-cycle pulse when a frame is dropped.
- REQ-013 SHALL have port ovf_count  out  OVF_CNT_WIDTH  dropped-frame count.

Function
- REQ-014 SHALL register AUD_ADC_CLK each cycle (lrc_q); rising edge = lrc_q 0 and AUD_ADC_CLK 1; falling edge = the converse.
- REQ-015 SHALL implement states SYNC, LEFT, RIGHT; reset enters SYNC; SYNC -> LEFT only on a rising edge; LEFT -> RIGHT on falling edge; RIGHT -> LEFT on rising edge.
- REQ-016 SHALL hold locked low in SYNC and high in LEFT/RIGHT; no capture occurs in SYNC, so partial first frames are discarded.
- REQ-017 SHALL zero the per-slot bit counter on each LRC edge and shift in AUD_ADC_DATA MSB-first, first bit on the edge cycle (I2S_MODE=0) or the cycle after (I2S_MODE=1).
- REQ-018 SHALL capture at most DATA_WIDTH bits per slot; further bits in a longer slot are ignored.
- REQ-019 SHALL left-align a short slot (fewer than DATA_WIDTH bits before the next edge) and zero-fill the missing LSBs.
- REQ-020 SHALL commit a frame on the rising edge ending a RIGHT slot: on that edge data_sig loads {left, right} and wrreq_sig is high for exactly the following cycle.
- REQ-021 SHALL keep data_sig stable between commits; capture of the next left slot SHALL NOT disturb data_sig.
- REQ-022 SHALL, if wrfull_sig is high at the commit edge, suppress wrreq_sig, leave data_sig unchanged, and pulse overflow_sig for one cycle.
- REQ-023 SHALL never assert wrreq_sig in consecutive cycles or while in SYNC.
- REQ-024 SHALL treat the first rising edge after SYNC as frame start only, with no commit.

Reset
- REQ-025 SHALL, on reset_n low, immediately drive wrreq_sig=0, overflow_sig=0, locked=0, data_sig=0, ovf_count=0, clear counters and shift registers, and set lrc_q=1.
- REQ-026 SHALL, on deassertion mid-frame, remain in SYNC until the next rising LRC edge; no partial frame is ever written.

Configuration
- REQ-027 SHALL compile the overflow counter only when AUDIO_RX_OVF_CNT_EN is defined: ovf_count then increments by one per dropped frame and saturates at all-ones.
- REQ-028 SHALL, without AUDIO_RX_OVF_CNT_EN, tie ovf_count to zero with no counter logic; overflow_sig is unaffected.

Verification
- REQ-029 SHALL check I2S_MODE=1, DATA_WIDTH=16, 32 BCLK/slot, left=0xA5C3 right=0x1234 -> one wrreq_sig pulse with data_sig=0xA5C31234 after the closing rising LRC edge.
- REQ-030 SHALL check I2S_MODE=0, DATA_WIDTH=24, left=0x800001 right=0x7FFFFE -> data_sig=0x8000017FFFFE.
- REQ-031 SHALL check DATA_WIDTH=16 with 12-BCLK slots, left bits 0xABC, right bits 0x123 -> data_sig=0xABC01230.
- REQ-032 SHALL check reset released mid-left-slot -> locked low and no wrreq_sig until the first full frame commits.
- REQ-033 SHALL check wrfull_sig high across 3 commits -> no wrreq_sig, 3 overflow_sig pulses, ovf_count=3 (0 without AUDIO_RX_OVF_CNT_EN), data_sig unchanged.
- REQ-034 SHALL check OVF_CNT_WIDTH=2 with 5 dropped frames -> ovf_count saturates at 3.
